// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_universal
// Brief    : Universal shift register (hold/shift/rotate/load/clear) with a
//            shift counter that pulses frame_done after each WIDTH-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_universal #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic                         sin,
    input  logic [WIDTH-1:0]             pin,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_r,
    output logic                         sout_l,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         frame_done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] c_HOLD  = 3'b000;
    localparam logic [2:0] c_SHR   = 3'b001;
    localparam logic [2:0] c_SHL   = 3'b010;
    localparam logic [2:0] c_LOAD  = 3'b011;
    localparam logic [2:0] c_ROTR  = 3'b100;
    localparam logic [2:0] c_ROTL  = 3'b101;
    localparam logic [2:0] c_CLR   = 3'b110;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] w_q_next;
    logic             w_is_shift;
    logic             w_is_reload;

    always_comb begin
        w_q_next    = q;
        w_is_shift  = 1'b0;
        w_is_reload = 1'b0;
        case (mode)
            c_SHR: begin
                w_q_next   = {sin, q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_SHL: begin
                w_q_next   = {q[WIDTH-2:0], sin};
                w_is_shift = 1'b1;
            end
            c_LOAD: begin
                w_q_next    = pin;
                w_is_reload = 1'b1;
            end
            c_ROTR: begin
                w_q_next   = {q[0], q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_ROTL: begin
                w_q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                w_is_shift = 1'b1;
            end
            c_CLR: begin
                w_q_next    = '0;
                w_is_reload = 1'b1;
            end
            c_HOLD:  w_q_next = q;
            default: w_q_next = q;  // 3'b111 is reserved and behaves as HOLD
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q          <= RESET_VAL;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (en) begin
            q          <= w_q_next;
            frame_done <= 1'b0;
            if (w_is_reload) begin
                cnt <= '0;
            end else if (w_is_shift) begin
                if (cnt == c_CNT_LAST) begin
                    cnt        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_universal
// Brief    : Directed self-checking bench for shift_reg_universal (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_universal;

    localparam int WIDTH = 4;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] SHR  = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] LOAD = 3'b011;
    localparam logic [2:0] ROTR = 3'b100;
    localparam logic [2:0] ROTL = 3'b101;
    localparam logic [2:0] CLR  = 3'b110;
    localparam logic [2:0] RSVD = 3'b111;

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [2:0]       cnt;
    logic             frame_done;

    int checks = 0;
    int errors = 0;

    shift_reg_universal #(
        .WIDTH     (WIDTH),
        .RESET_VAL (4'b0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .sin        (sin),
        .pin        (pin),
        .q          (q),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .cnt        (cnt),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic s,
                         input logic [3:0] p);
        en   = e;
        mode = m;
        sin  = s;
        pin  = p;
    endtask

    task automatic test_reset();
        drive(1'b1, LOAD, 1'b0, 4'b1000);
        step();
        drive(1'b1, SHR, 1'b0, 4'b0000);
        step();
        drive(1'b1, SHR, 1'b1, 4'b0000);
        step();
        checks++;
        if (q !== 4'b1010 || cnt !== 3'd2) begin
            errors++;
            $display("FAIL reset_setup: got q=%b cnt=%0d want q=1010 cnt=2", q, cnt);
        end
        drive(1'b1, SHR, 1'b1, 4'b0000);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (q !== 4'b0000 || cnt !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got q=%b cnt=%0d fd=%b want q=0000 cnt=0 fd=0",
                     q, cnt, frame_done);
        end
        step();
        checks++;
        if (q !== 4'b0000 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_override: got q=%b cnt=%0d want q=0000 cnt=0", q, cnt);
        end
        drive(1'b0, HOLD, 1'b0, 4'b0000);
        #2 reset = 1'b0;
        step();
    endtask

    task automatic test_sipo();
        logic [3:0] sins;
        logic [3:0] exp_q [4];
        sins = 4'b1101;  // applied LSB first: 1,0,1,1
        exp_q[0] = 4'b1000; exp_q[1] = 4'b0100; exp_q[2] = 4'b1010; exp_q[3] = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, SHR, sins[i], 4'b0000);
            step();
            checks++;
            if (q !== exp_q[i] || frame_done !== (i == 3) || cnt !== 3'((i + 1) % 4)) begin
                errors++;
                $display("FAIL sipo_%0d: got q=%b fd=%b cnt=%0d want q=%b fd=%b cnt=%0d",
                         i, q, frame_done, cnt, exp_q[i], (i == 3), (i + 1) % 4);
            end
        end
        drive(1'b1, HOLD, 1'b0, 4'b0000);
        step();
        checks++;
        if (frame_done !== 1'b0 || q !== 4'b1101) begin
            errors++;
            $display("FAIL sipo_pulse_width: got fd=%b q=%b want fd=0 q=1101", frame_done, q);
        end
    endtask

    task automatic test_piso();
        logic [3:0] exp_sout;
        int         pulses;
        exp_sout = 4'b1001;
        pulses   = 0;
        drive(1'b1, LOAD, 1'b0, 4'b1001);
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sout_r !== exp_sout[i]) begin
                errors++;
                $display("FAIL piso_sout_%0d: got %b want %b", i, sout_r, exp_sout[i]);
            end
            drive(1'b1, SHR, 1'b0, 4'b0000);
            step();
            if (frame_done === 1'b1) pulses++;
        end
        drive(1'b1, HOLD, 1'b0, 4'b0000);
        step();
        if (frame_done === 1'b1) pulses++;
        checks++;
        if (q !== 4'b0000 || pulses != 1) begin
            errors++;
            $display("FAIL piso_final: got q=%b pulses=%0d want q=0000 pulses=1", q, pulses);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_q [4];
        exp_q[0] = 4'b0010; exp_q[1] = 4'b0100; exp_q[2] = 4'b1000; exp_q[3] = 4'b0001;
        drive(1'b1, LOAD, 1'b0, 4'b0001);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ROTL, 1'b0, 4'b0000);
            step();
            checks++;
            if (q !== exp_q[i] || frame_done !== (i == 3)) begin
                errors++;
                $display("FAIL rotl_%0d: got q=%b fd=%b want q=%b fd=%b",
                         i, q, frame_done, exp_q[i], (i == 3));
            end
        end
        drive(1'b1, ROTR, 1'b1, 4'b0000);
        step();
        checks++;
        if (q !== 4'b1000 || cnt !== 3'd1 || sout_l !== 1'b1 || sout_r !== 1'b0
            || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rotr: got q=%b cnt=%0d sl=%b sr=%b fd=%b want q=1000 cnt=1 sl=1 sr=0 fd=0",
                     q, cnt, sout_l, sout_r, frame_done);
        end
    endtask

    task automatic test_enable_hold();
        // q=1000, cnt=1 entering; one SHR brings cnt to 2
        drive(1'b1, SHR, 1'b1, 4'b0000);
        step();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b0, SHR, 1'b1, 4'b1111);
            else       drive(1'b1, (i == 3) ? HOLD : RSVD, 1'b1, 4'b1111);
            step();
            checks++;
            if (q !== 4'b1100 || cnt !== 3'd2 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got q=%b cnt=%0d fd=%b want q=1100 cnt=2 fd=0",
                         i, q, cnt, frame_done);
            end
        end
        drive(1'b1, SHR, 1'b0, 4'b0000);
        step();
        checks++;
        if (q !== 4'b0110 || cnt !== 3'd3 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL hold_resume1: got q=%b cnt=%0d fd=%b want q=0110 cnt=3 fd=0",
                     q, cnt, frame_done);
        end
        step();
        checks++;
        if (q !== 4'b0011 || cnt !== 3'd0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL hold_resume2: got q=%b cnt=%0d fd=%b want q=0011 cnt=0 fd=1",
                     q, cnt, frame_done);
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_q [3];
        exp_q[0] = 4'b0111; exp_q[1] = 4'b1111; exp_q[2] = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, SHL, 1'b1, 4'b0000);
            step();
            checks++;
            if (q !== exp_q[i] || cnt !== 3'(i + 1)) begin
                errors++;
                $display("FAIL prio_shl_%0d: got q=%b cnt=%0d want q=%b cnt=%0d",
                         i, q, cnt, exp_q[i], i + 1);
            end
        end
        drive(1'b1, LOAD, 1'b1, 4'b0110);
        step();
        checks++;
        if (q !== 4'b0110 || cnt !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL prio_load: got q=%b cnt=%0d fd=%b want q=0110 cnt=0 fd=0",
                     q, cnt, frame_done);
        end
        drive(1'b1, SHL, 1'b0, 4'b0000);
        step();
        drive(1'b1, CLR, 1'b1, 4'b1111);
        step();
        checks++;
        if (q !== 4'b0000 || cnt !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL prio_clr: got q=%b cnt=%0d fd=%b want q=0000 cnt=0 fd=0",
                     q, cnt, frame_done);
        end
    endtask

    task automatic test_back_to_back();
        // Mixed directions; every shift counts, pulse after shifts 4 and 8
        logic [2:0] modes [8];
        modes[0] = SHL;  modes[1] = SHR;  modes[2] = ROTL; modes[3] = ROTR;
        modes[4] = SHR;  modes[5] = SHL;  modes[6] = ROTR; modes[7] = SHL;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, modes[i], i[0], 4'b0000);
            step();
            checks++;
            if (frame_done !== (i == 3 || i == 7) || cnt !== 3'((i + 1) % 4)) begin
                errors++;
                $display("FAIL b2b_%0d: got fd=%b cnt=%0d want fd=%b cnt=%0d",
                         i, frame_done, cnt, (i == 3 || i == 7), (i + 1) % 4);
            end
        end
        drive(1'b0, SHR, 1'b1, 4'b0000);
        step();
        checks++;
        if (frame_done !== 1'b0 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL b2b_en_low: got fd=%b cnt=%0d want fd=0 cnt=0", frame_done, cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, HOLD, 1'b0, 4'b0000);
        step();
        step();
        checks++;
        if (q !== 4'b0000 || cnt !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL por_state: got q=%b cnt=%0d fd=%b want q=0000 cnt=0 fd=0",
                     q, cnt, frame_done);
        end
        #2 reset = 1'b0;
        step();

        test_reset();
        test_sipo();
        test_piso();
        test_rotate();
        test_enable_hold();
        test_priority();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
